// File: rtl/peak_report_pkg.sv
// Shared constants and types for the peak report block: field widths,
// report beat layout and the output FSM state encoding.
package peak_report_pkg;

  localparam int VALUE_WIDTH = 16;
  localparam int INDEX_WIDTH = 12;

  // Beat0 field offsets: {frame_count[15:0], sep[11:0], 2'b00, ovf, p2v}.
  localparam int BEAT0_FRAME_LSB = 16;
  localparam int BEAT0_SEP_LSB   = 4;
  localparam int BEAT0_SEP_WIDTH = 12;
  localparam int BEAT0_OVF_BIT   = 1;
  localparam int BEAT0_P2V_BIT   = 0;

  // Beat1/beat2 layout: {value zero-extended to 16, index zero-extended to 16}.
  localparam int BEAT_HI_LSB     = 16;
  localparam int BEAT_HALF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_BEAT2
  } state_t;

  // One frame report, pre-formatted as the three beats it is sent as.
  typedef struct packed {
    logic [31:0] beat0;
    logic [31:0] beat1;
    logic [31:0] beat2;
  } report_t;

  localparam int REPORT_WIDTH = $bits(report_t);

  function automatic logic [31:0] pack_beat0(
    input logic [15:0]                frame,
    input logic [BEAT0_SEP_WIDTH-1:0] sep,
    input logic                       ovf,
    input logic                       p2v
  );
    logic [31:0] beat;
    beat = '0;
    beat[BEAT0_FRAME_LSB +: 16]           = frame;
    beat[BEAT0_SEP_LSB +: BEAT0_SEP_WIDTH] = sep;
    beat[BEAT0_OVF_BIT]                   = ovf;
    beat[BEAT0_P2V_BIT]                   = p2v;
    return beat;
  endfunction

endpackage

// File: rtl/peak_report_fifo.sv
// Synchronous FIFO holding pending frame reports. Exposes the head entry and
// the one behind it so the reader can start the next report without a bubble.
// A write into a full FIFO is accepted when a read happens on the same edge.
module peak_report_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_next,
  output logic             full,
  output logic             empty,
  output logic             multi
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_addr_next;
  logic             do_wr;
  logic             do_rd;

  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == (AW+1)'(DEPTH));
  assign empty        = (count == '0);
  assign multi        = (count > (AW+1)'(1));
  assign do_rd        = rd_en && !empty;
  assign do_wr        = wr_en && (!full || do_rd);
  assign rd_addr_next = rd_ptr_q[AW-1:0] + AW'(1);
  assign dout         = mem_q[rd_ptr_q[AW-1:0]];
  assign dout_next    = mem_q[rd_addr_next];

  // Storage array write port.
  // NOTE: the storage array is deliberately left out of reset; the pointers
  // alone define which entries are valid, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Read/write pointers; the extra MSB separates full from empty.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/peak_report.sv
// Captures the two strongest peaks at each end of frame, queues the report and
// streams it as three AXI-Stream beats. Tracks frames seen and frames dropped.
module peak_report #(
  parameter int VALUE_WIDTH = peak_report_pkg::VALUE_WIDTH,
  parameter int INDEX_WIDTH = peak_report_pkg::INDEX_WIDTH,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   last_in,
  input  logic [VALUE_WIDTH-1:0] peak1_in,
  input  logic [VALUE_WIDTH-1:0] peak2_in,
  input  logic [INDEX_WIDTH-1:0] index1_in,
  input  logic [INDEX_WIDTH-1:0] index2_in,
  output logic [31:0]            m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [7:0]             drop_count,
  output logic [15:0]            frame_count
);

  import peak_report_pkg::*;

  state_t           state_q, state_d;
  logic [31:0]      tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic [7:0]       drop_q, drop_d;
  logic [15:0]      frame_q, frame_d;
  logic             pending_ovf_q, pending_ovf_d;

  logic [INDEX_WIDTH-1:0] sep_raw;
  logic [15:0]            frame_next;
  report_t                wr_report;
  report_t                head_report;
  report_t                after_report;
  report_t                next_report;
  logic                   capture;
  logic                   pop;
  logic                   fifo_wr;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_multi;

  // Capture side: a frame is written unless the FIFO stays full this edge.
  assign capture    = last_in && !reset;
  assign pop        = (state_q == ST_BEAT2) && m_tready;
  assign fifo_wr    = capture && (!fifo_full || pop);
  assign drop       = capture && !fifo_wr;
  assign frame_next = frame_q + 16'd1;
  assign sep_raw    = index1_in - index2_in;

  assign wr_report.beat0 = pack_beat0(frame_next, BEAT0_SEP_WIDTH'(sep_raw),
                                      pending_ovf_q, (peak2_in != '0));
  assign wr_report.beat1 = {BEAT_HALF_WIDTH'(peak1_in), BEAT_HALF_WIDTH'(index1_in)};
  assign wr_report.beat2 = {BEAT_HALF_WIDTH'(peak2_in), BEAT_HALF_WIDTH'(index2_in)};

  peak_report_fifo #(
    .WIDTH (REPORT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (fifo_wr),
    .rd_en     (pop),
    .din       (wr_report),
    .dout      (head_report),
    .dout_next (after_report),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .multi     (fifo_multi)
  );

  // After popping the head, the next report is either already queued behind it
  // or is the one being written on this very edge.
  assign next_report = fifo_multi ? after_report : wr_report;

  // Frame/drop counters and the pending-overflow marker.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    frame_d       = frame_q;
    drop_d        = drop_q;
    pending_ovf_d = pending_ovf_q;
    if (capture) frame_d = frame_next;
    if (drop) begin
      pending_ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (fifo_wr && pending_ovf_q) begin
      pending_ovf_d = 1'b0;
    end
  end

  // Output FSM: walks the three beats and preloads the registered beat data.
  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_BEAT0;
          tdata_d = head_report.beat0;
          tlast_d = 1'b0;
        end
      end
      ST_BEAT0: begin
        if (m_tready) begin
          state_d = ST_BEAT1;
          tdata_d = head_report.beat1;
        end
      end
      ST_BEAT1: begin
        if (m_tready) begin
          state_d = ST_BEAT2;
          tdata_d = head_report.beat2;
          tlast_d = 1'b1;
        end
      end
      ST_BEAT2: begin
        if (m_tready) begin
          tlast_d = 1'b0;
          if (fifo_multi || fifo_wr) begin
            state_d = ST_BEAT0;
            tdata_d = next_report.beat0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, output and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tdata_q       <= '0;
      tlast_q       <= 1'b0;
      drop_q        <= '0;
      frame_q       <= '0;
      pending_ovf_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tdata_q       <= tdata_d;
      tlast_q       <= tlast_d;
      drop_q        <= drop_d;
      frame_q       <= frame_d;
      pending_ovf_q <= pending_ovf_d;
    end
  end

  assign m_tvalid    = (state_q != ST_IDLE);
  assign m_tdata     = tdata_q;
  assign m_tlast     = tlast_q;
  assign drop_count  = drop_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_peak_report.sv
// Scoreboard bench for peak_report: stimulus pushes expected beats, a monitor
// compares every accepted beat; counters and latency are checked directly.
module tb_peak_report;

  logic        clk = 1'b0;
  logic        reset;
  logic        last_in;
  logic [15:0] peak1, peak2;
  logic [11:0] idx1, idx2;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [7:0]  drop_count;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  always #5 clk = ~clk;

  peak_report dut (
    .clk         (clk),
    .reset       (reset),
    .last_in     (last_in),
    .peak1_in    (peak1),
    .peak2_in    (peak2),
    .index1_in   (idx1),
    .index2_in   (idx2),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .drop_count  (drop_count),
    .frame_count (frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_report(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
    exp_q.push_back('{b0, 1'b0});
    exp_q.push_back('{b1, 1'b0});
    exp_q.push_back('{b2, 1'b1});
  endtask

  task automatic set_inputs(input logic [15:0] p1, input logic [11:0] i1,
                            input logic [15:0] p2, input logic [11:0] i2);
    peak1 = p1;
    idx1  = i1;
    peak2 = p2;
    idx2  = i2;
  endtask

  // Hold last_in high for n consecutive edges; returns just after the last one.
  task automatic capture_n(input int n);
    last_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    last_in = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && !m_tvalid; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(m_tvalid), 32'd1);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got 0x%08h with nothing expected at %0t", m_tdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", m_tdata, mon_e.data);
        check("beat_last", 32'(m_tlast), 32'(mon_e.last));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    last_in  = 1'b1;
    m_tready = 1'b0;
    set_inputs(16'h0, 12'h0, 16'h0, 12'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(m_tvalid), 32'd0);
    check("reset_data",  m_tdata, 32'd0);
    check("reset_last",  32'(m_tlast), 32'd0);
    check("reset_drop",  32'(drop_count), 32'd0);
    check("reset_frame", 32'(frame_count), 32'd0);
    reset   = 1'b0;
    last_in = 1'b0;

    // Single frame, ready held high; two-cycle latency to first valid.
    m_tready = 1'b1;
    set_inputs(16'h0123, 12'h045, 16'h0010, 12'h030);
    push_report(32'h0001_0151, 32'h0123_0045, 32'h0010_0030);
    capture_n(1);
    check("latency_edge_n", 32'(m_tvalid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_edge_n1", 32'(m_tvalid), 32'd1);
    check("first_beat0", m_tdata, 32'h0001_0151);
    wait_drain(20, "drain_single");
    check("frame_single", 32'(frame_count), 32'd1);

    // Backpressure during beat1; also sep wrap and p2v=0.
    m_tready = 1'b0;
    set_inputs(16'h0ABC, 12'h100, 16'h0000, 12'h200);
    push_report(32'h0002_F000, 32'h0ABC_0100, 32'h0000_0200);
    capture_n(1);
    wait_valid(10, "bp_wait_valid");
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data",  m_tdata, 32'h0ABC_0100);
      check("bp_hold_valid", 32'(m_tvalid), 32'd1);
      check("bp_hold_last",  32'(m_tlast), 32'd0);
      @(posedge clk);
      #1;
    end
    m_tready = 1'b1;
    wait_drain(20, "drain_bp");

    // Overflow: four frames into a two-deep FIFO with the sink stalled.
    m_tready = 1'b0;
    set_inputs(16'h0111, 12'h010, 16'h0022, 12'h008);
    push_report(32'h0003_0081, 32'h0111_0010, 32'h0022_0008);
    push_report(32'h0004_0081, 32'h0111_0010, 32'h0022_0008);
    capture_n(4);
    check("ovf_drop",  32'(drop_count), 32'd2);
    check("ovf_frame", 32'(frame_count), 32'd6);
    m_tready = 1'b1;
    wait_drain(30, "drain_ovf");
    push_report(32'h0007_0083, 32'h0111_0010, 32'h0022_0008);
    capture_n(1);
    wait_drain(20, "drain_ovf_flag");
    check("ovf_frame_after", 32'(frame_count), 32'd7);

    // Capture on the beat2 handshake edge with the FIFO full: no drop.
    m_tready = 1'b0;
    push_report(32'h0008_0081, 32'h0111_0010, 32'h0022_0008);
    push_report(32'h0009_0081, 32'h0111_0010, 32'h0022_0008);
    capture_n(2);
    m_tready = 1'b1;
    for (int i = 0; i < 10 && !(m_tvalid && m_tlast); i++) begin
      @(posedge clk);
      #1;
    end
    check("reach_beat2", 32'(m_tlast), 32'd1);
    push_report(32'h000A_0081, 32'h0111_0010, 32'h0022_0008);
    capture_n(1);
    check("full_pop_drop", 32'(drop_count), 32'd2);
    wait_drain(30, "drain_full_pop");
    check("full_pop_frame", 32'(frame_count), 32'd10);

    // Index difference wrapping below zero.
    set_inputs(16'h0F00, 12'h005, 16'h0001, 12'hFFA);
    push_report(32'h000B_00B1, 32'h0F00_0005, 32'h0001_0FFA);
    capture_n(1);
    wait_drain(20, "drain_sep_wrap");

    // Frame counter wrap and drop counter saturation.
    m_tready = 1'b0;
    set_inputs(16'h00AA, 12'h003, 16'h0000, 12'h001);
    push_report(32'h000C_0020, 32'h00AA_0003, 32'h0000_0001);
    push_report(32'h000D_0020, 32'h00AA_0003, 32'h0000_0001);
    capture_n(65525);
    check("wrap_frame", 32'(frame_count), 32'd0);
    check("sat_drop",   32'(drop_count), 32'd255);
    m_tready = 1'b1;
    wait_drain(30, "drain_wrap");
    push_report(32'h0001_0022, 32'h00AA_0003, 32'h0000_0001);
    capture_n(1);
    wait_drain(20, "drain_wrap_ovf");
    check("wrap_frame_after", 32'(frame_count), 32'd1);
    check("sat_drop_after",   32'(drop_count), 32'd255);

    // Reset during beat1 with last_in coincident; pending overflow also set.
    m_tready = 1'b0;
    exp_q.push_back('{32'h0002_0020, 1'b0});
    capture_n(3);
    wait_valid(10, "rst_wait_valid");
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    check("rst_beat0_taken", 32'(exp_q.size()), 32'd0);
    reset   = 1'b1;
    last_in = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    last_in = 1'b0;
    check("midrst_valid", 32'(m_tvalid), 32'd0);
    check("midrst_data",  m_tdata, 32'd0);
    check("midrst_last",  32'(m_tlast), 32'd0);
    check("midrst_frame", 32'(frame_count), 32'd0);
    check("midrst_drop",  32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_idle_valid", 32'(m_tvalid), 32'd0);
    m_tready = 1'b1;
    push_report(32'h0001_0020, 32'h00AA_0003, 32'h0000_0001);
    capture_n(1);
    wait_drain(20, "drain_post_reset");
    check("post_reset_frame", 32'(frame_count), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/peak_report.md
PEAK_REPORT -- requirements
Module: peak_report

Interface
REQ-001 Parameter VALUE_WIDTH, default `VALUE_WIDTH (16), peak magnitude width.
REQ-002 Parameter INDEX_WIDTH, default `INDEX_WIDTH (12), bin index width.
REQ-003 Parameter FIFO_DEPTH, default 2, number of buffered frame reports (power of two, >=2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 last_in  input  1  single-cycle end-of-frame strobe from the peak stage's last_out.
REQ-007 peak1_in, peak2_in  input  VALUE_WIDTH each  largest and second peak of the finished frame.
REQ-008 index1_in, index2_in  input  INDEX_WIDTH each  bin indices of those peaks.
REQ-009 m_tdata  output  32  report word; m_tvalid  output  1; m_tready  input  1; m_tlast  output  1 (AXI-Stream master).
REQ-010 drop_count  output  8  saturating count of frames lost to full FIFO.
REQ-011 frame_count  output  16  frames seen since reset, including dropped frames.

Function
REQ-012 On a clock edge with last_in=1, the block SHALL sample all four peak/index inputs and increment frame_count (mod 2^16).
REQ-013 A sampled report SHALL be written to the FIFO on the same edge, unless the FIFO is full after any pop on that edge.
REQ-014 Full FIFO on capture: report discarded; drop_count +1, saturating at 255; pending_ovf flag set.
REQ-015 Simultaneous capture and BEAT2 handshake with a full FIFO: pop frees an entry; the write SHALL be accepted, with no drop.
REQ-016 Each report SHALL contain three beats, sent in order.
REQ-016a Beat0 = {frame_count at capture[15:0], sep[11:0], 2'b00, ovf, p2v}. sep = (index1_in - index2_in) mod 2^INDEX_WIDTH. p2v = (peak2_in != 0). ovf = pending_ovf at capture.
REQ-017 Beat1 = {peak1 zero-extended to 16, index1 zero-extended to 16}. Beat2 = same layout for peak2/index2. m_tlast=1 on beat2 only.
REQ-018 pending_ovf SHALL clear when a report is written carrying ovf=1.
REQ-019 Output FSM states: IDLE, BEAT0, BEAT1, BEAT2.
REQ-019a IDLE->BEAT0 when FIFO is non-empty.
REQ-019b BEAT0->BEAT1 and BEAT1->BEAT2 on m_tvalid&&m_tready.
REQ-019c BEAT2 handshake: pop the FIFO; go to BEAT0 if another entry remains, else IDLE (no bubble between back-to-back reports).
REQ-020 m_tvalid=1 exactly in states BEAT0..BEAT2.
REQ-020a m_tdata and m_tlast SHALL be registered outputs.
REQ-020b m_tdata and m_tlast SHALL hold stable while m_tvalid&&!m_tready.
REQ-021 Latency: last_in at edge N with the FIFO empty and FSM in IDLE -> beat0 presented with m_tvalid=1 in the cycle after edge N+1.
REQ-022 m_tvalid SHALL NOT depend combinationally on m_tready.

Reset
REQ-023 reset=1 at an edge SHALL set: FSM to IDLE; FIFO empty; m_tvalid=0; m_tlast=0; m_tdata=0; drop_count=0; frame_count=0; pending_ovf=0.
REQ-024 Reset mid-report SHALL abandon the current report; m_tvalid SHALL be low in the cycle after the reset edge.
REQ-025 last_in coincident with reset SHALL be ignored.

Structure
REQ-026 VALUE_WIDTH, INDEX_WIDTH and the beat field offsets SHALL be defined in the shared constants.vh.
REQ-027 Report storage SHALL be a sub-module peak_report_fifo, a synchronous FIFO.
REQ-027a peak_report_fifo ports: wr_en, rd_en, din, dout, full, empty. Same-cycle read+write allowed when full.
REQ-028 The FSM and beat mux SHALL live in peak_report; total RTL 150-300 lines.

Verification
REQ-029 Single frame:
- Stimulus: peak1=0x0123, index1=0x045, peak2=0x0010, index2=0x030; last_in pulse; m_tready=1.
- Expected: beats 0x0001_0151 (frame_count=1, sep=0x015, p2v=1), then 0x0123_0045, then 0x0010_0030; m_tlast on beat3 only; m_tvalid first high 2 cycles after last_in.
REQ-030 Backpressure: hold m_tready=0 for 5 cycles during beat1 -> m_tdata constant and m_tvalid held high; then beat2 follows after m_tready rises.
REQ-031 Overflow:
- Stimulus: m_tready=0; 4 last_in pulses.
- Expected: 2 reports stored; drop_count=2; frame_count=4.
- Next: release m_tready, then one more capture -> that report has ovf=1; the two stored reports have ovf=0.
REQ-032 Full plus pop: last_in on the same edge as the BEAT2 handshake with the FIFO full -> drop_count unchanged; three reports eventually emitted.
REQ-033 Wrap and saturation:
- sep: index1=0x005, index2=0xFFA -> sep=0x00B.
- drop_count: 300 drops -> drop_count=255.
- frame_count: 65536 frames -> frame_count=0.
REQ-034 Reset asserted during beat1 -> next cycle m_tvalid=0, and all counters read 0.
